// File: rtl/spin_pkg.sv
// spin_pkg: state encoding and LFSR constants shared by the roulette spin sequencer.
package spin_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FAST,
        ST_SLOW,
        ST_SETTLE
    } state_t;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/spin_lfsr.sv
// spin_lfsr: free-running 16-bit Galois LFSR, right-shifting, reseeded by rst.
module spin_lfsr
    import spin_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] lfsr_out
);

    logic [15:0] lfsr_q, lfsr_d;

    always_comb lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr_q <= LFSR_SEED;
        else     lfsr_q <= lfsr_d;
    end

    assign lfsr_out = lfsr_q;

endmodule

// File: rtl/spin_sequencer.sv
// spin_sequencer: 8-LED roulette wheel spin (fast, decelerating slow, settle, stop).
// Define SPIN_FORCE_RESULT_EN to add force_en/force_pos for choosing the landing position.
module spin_sequencer
    import spin_pkg::*;
#(
    parameter logic [31:0] FAST_DIV   = 32'd2_500_000,
    parameter logic [31:0] FAST_STEPS = 32'd24,
    parameter logic [31:0] SLOW_INC   = 32'd500_000,
    parameter logic [31:0] SLOW_STEPS = 32'd8,
    parameter logic [31:0] HOLD       = 32'd25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
`ifdef SPIN_FORCE_RESULT_EN
    input  logic       force_en,
    input  logic [2:0] force_pos,
`endif
    output logic [7:0] led_out,
    output logic [2:0] result_pos,
    output logic       busy,
    output logic       slowing,
    output logic       step_tick,
    output logic       done
);

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d, step_q, step_d, period_q, period_d;
    logic [2:0]  extra_q, extra_d, pos_q, pos_d, pos_inc;
    logic [7:0]  led_q, led_d;
    logic        busy_q, busy_d, slowing_q, slowing_d, tick_q, tick_d, done_q, done_d;
    logic [15:0] lfsr;
    logic        force_hit;
    logic [2:0]  force_val;
    logic        unused_lfsr;

    spin_lfsr u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .lfsr_out (lfsr)
    );

    assign unused_lfsr = ^lfsr[15:3];

`ifdef SPIN_FORCE_RESULT_EN
    assign force_hit = force_en;
    assign force_val = force_pos;
`else
    assign force_hit = 1'b0;
    assign force_val = 3'd0;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        step_d   = step_q;
        period_d = period_q;
        extra_d  = extra_q;
        pos_d    = pos_q;
        tick_d   = 1'b0;
        done_d   = 1'b0;
        pos_inc  = pos_q + 3'd1;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d = ST_FAST;
                    cnt_d   = '0;
                    step_d  = '0;
                    extra_d = lfsr[2:0];
                end
            end
            ST_FAST: begin
                if (cnt_q == FAST_DIV - 32'd1) begin
                    cnt_d  = '0;
                    pos_d  = pos_inc;
                    tick_d = 1'b1;
                    step_d = step_q + 32'd1;
                    if (step_q == FAST_STEPS - 32'd1) begin
                        state_d  = ST_SLOW;
                        step_d   = '0;
                        period_d = FAST_DIV + SLOW_INC;
                        // Choose the slow-step count so the last slow step lands on force_pos
                        extra_d  = force_hit ? force_val - pos_inc - SLOW_STEPS[2:0] : extra_q;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_SLOW: begin
                if (cnt_q == period_q - 32'd1) begin
                    cnt_d    = '0;
                    pos_d    = pos_inc;
                    tick_d   = 1'b1;
                    step_d   = step_q + 32'd1;
                    period_d = period_q + SLOW_INC;
                    if (step_q == SLOW_STEPS - 32'd1 + {29'd0, extra_q}) state_d = ST_SETTLE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == HOLD - 32'd1) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Abort overrides any step or completion scheduled for this cycle
        if (abort && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            step_d  = '0;
            pos_d   = pos_q;
            tick_d  = 1'b0;
            done_d  = 1'b0;
        end
        busy_d    = state_d != ST_IDLE;
        slowing_d = state_d == ST_SLOW || state_d == ST_SETTLE;
        led_d     = 8'd1 << pos_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            step_q    <= '0;
            period_q  <= '0;
            extra_q   <= '0;
            pos_q     <= '0;
            led_q     <= 8'h01;
            busy_q    <= 1'b0;
            slowing_q <= 1'b0;
            tick_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            step_q    <= step_d;
            period_q  <= period_d;
            extra_q   <= extra_d;
            pos_q     <= pos_d;
            led_q     <= led_d;
            busy_q    <= busy_d;
            slowing_q <= slowing_d;
            tick_q    <= tick_d;
            done_q    <= done_d;
        end
    end

    assign led_out    = led_q;
    assign result_pos = pos_q;
    assign busy       = busy_q;
    assign slowing    = slowing_q;
    assign step_tick  = tick_q;
    assign done       = done_q;

endmodule

// File: tb/tb_spin_sequencer.sv
// tb_spin_sequencer: directed checks of spin timing, landing position, abort and reset.
module tb_spin_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       force_en = 1'b0;
    logic [2:0] force_pos = 3'd0;
    logic [7:0] led_out;
    logic [2:0] result_pos;
    logic       busy, slowing, step_tick, done;

    int checks = 0;
    int errors = 0;
    logic [15:0] m_lfsr;
    int tick_q[$];
    int done_at, n_dones, busy1, busy_end;

    always #5 clk = ~clk;

    spin_sequencer #(
        .FAST_DIV   (32'd4),
        .FAST_STEPS (32'd8),
        .SLOW_INC   (32'd2),
        .SLOW_STEPS (32'd8),
        .HOLD       (32'd3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
`ifdef SPIN_FORCE_RESULT_EN
        .force_en   (force_en),
        .force_pos  (force_pos),
`endif
        .led_out    (led_out),
        .result_pos (result_pos),
        .busy       (busy),
        .slowing    (slowing),
        .step_tick  (step_tick),
        .done       (done)
    );

    // Reference Galois LFSR: shift right, xor B400 when the dropped bit is 1
    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Offsets count negedges after the one where start was raised
    task automatic spin(input int rs1, input int rs2);
        int off;
        tick_q.delete();
        done_at = -1;
        n_dones = 0;
        busy1   = 0;
        start   = 1'b1;
        off     = 0;
        while (done_at < 0 && off < 2000) begin
            @(negedge clk);
            off++;
            start = (off == rs1) || (off == rs2);
            if (off == 1) busy1 = int'(busy);
            if (step_tick) tick_q.push_back(off);
            if (done) begin
                done_at = off;
                n_dones++;
            end
        end
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) n_dones++;
            if (step_tick) tick_q.push_back(-1);
        end
        busy_end = int'(busy);
    endtask

    task automatic run(input int idx, input int rs1, input int rs2);
        int p0, e, n, fp, exp_t, j;
        p0 = int'(result_pos);
        e  = int'(m_lfsr[2:0]);
`ifdef SPIN_FORCE_RESULT_EN
        if (force_en) e = int'(3'(force_pos - result_pos));
`endif
        n = 8 + e;
        spin(rs1, rs2);
        check($sformatf("spin%0d_timeout", idx), int'(done_at < 0), 0);
        check($sformatf("spin%0d_busy1", idx), busy1, 1);
        check($sformatf("spin%0d_ticks", idx), tick_q.size(), 8 + n);
        check($sformatf("spin%0d_nrange", idx), int'(tick_q.size() >= 16 && tick_q.size() <= 23), 1);
        for (int i = 0; i < tick_q.size() && i < 8 + n; i++) begin
            j = i - 7;
            exp_t = (i < 8) ? 1 + 4 * (i + 1) : 33 + 4 * j + j * (j + 1);
            check($sformatf("spin%0d_tick%0d", idx, i), tick_q[i], exp_t);
        end
        check($sformatf("spin%0d_done_at", idx), done_at, 33 + 4 * n + n * (n + 1) + 3);
        check($sformatf("spin%0d_dones", idx), n_dones, 1);
        check($sformatf("spin%0d_busy_end", idx), busy_end, 0);
        fp = (p0 + n) % 8;
        check($sformatf("spin%0d_pos", idx), int'(result_pos), fp);
        check($sformatf("spin%0d_led", idx), int'(led_out), 1 << fp);
    endtask

    initial begin
        int frozen, cnt, e, n, d;
        repeat (3) @(negedge clk);
        check("rst_led", int'(led_out), 8'h01);
        check("rst_pos", int'(result_pos), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_slowing", int'(slowing), 0);
        check("rst_tick", int'(step_tick), 0);
        rst = 1'b0;
        @(negedge clk);

`ifdef SPIN_FORCE_RESULT_EN
        force_en  = 1'b1;
        force_pos = 3'd5;
`endif
        run(0, -1, -1);
`ifdef SPIN_FORCE_RESULT_EN
        check("forced_pos", int'(result_pos), 5);
        check("forced_led", int'(led_out), 8'h20);
        force_en = 1'b0;
`endif

        run(1, 10, 60);
        for (int i = 0; i < 64; i++) run(i + 2, -1, -1);

        // abort partway through the slow phase
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (59) @(negedge clk);
        check("abort_in_slow", int'(slowing), 1);
        frozen = int'(result_pos);
        abort  = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_slowing", int'(slowing), 0);
        check("abort_done", int'(done), 0);
        check("abort_tick", int'(step_tick), 0);
        check("abort_pos", int'(result_pos), frozen);
        cnt = 0;
        repeat (300) begin
            @(negedge clk);
            cnt += int'(done) + int'(step_tick) + int'(busy);
        end
        check("abort_quiet", cnt, 0);
        check("abort_pos_held", int'(result_pos), frozen);
        run(100, -1, -1);

        // start and abort together in IDLE: abort wins
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("idle_abort_busy", int'(busy), 0);
        repeat (5) @(negedge clk);
        check("idle_abort_noqueue", int'(busy), 0);

        // reset during SETTLE
        e = int'(m_lfsr[2:0]);
        n = 8 + e;
        d = 33 + 4 * n + n * (n + 1) + 3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (d - 3) @(negedge clk);
        check("settle_slowing", int'(slowing), 1);
        check("settle_busy", int'(busy), 1);
        #2 rst = 1'b1;
        #1;
        check("midrst_led", int'(led_out), 8'h01);
        check("midrst_pos", int'(result_pos), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_slowing", int'(slowing), 0);
        check("midrst_done", int'(done), 0);
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            cnt += int'(done);
        end
        check("midrst_nodone", cnt, 0);
        rst = 1'b0;
        @(negedge clk);
        run(101, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
